dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width of the local data memory (2^ADDR_W bytes).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning extra wait cycles inserted before each access.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  MEM-stage initiator presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  mem_size_t  access size and signedness (B, H, W, BU, HU).
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load data, extended per req_size; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  access faulted; no memory side effect.

Function
REQ-015 SHALL implement the FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE; WAIT is skipped when WAIT_CYCLES = 0.
REQ-016 IDLE: req_ready = 1; on req_valid the request is latched and the next state is WAIT (or ACCESS if WAIT_CYCLES = 0).
REQ-017 req_ready SHALL be 0 in every state other than IDLE; no request is accepted while one is outstanding.
REQ-018 WAIT: a 4-bit counter is loaded with WAIT_CYCLES-1 on acceptance and decrements; the FSM moves to ACCESS when it reads 0.
REQ-019 ACCESS: stores write the byte lanes selected by size and addr[1:0]; loads issue a synchronous read; the next state is RESP.
REQ-020 RESP: resp_valid = 1 with stable rdata/err until resp_ready = 1, then IDLE.
REQ-021 Latency from the accepting edge to resp_valid SHALL be 2 + WAIT_CYCLES cycles, with zero-wait resp_ready.
REQ-022 Loads: B/H sign-extend; BU/HU zero-extend; W returns the full word; lane selected by addr[1:0].
REQ-023 Stores: SB writes 1 byte and SH writes 2 bytes from the low bits of req_wdata; SW writes 4 bytes; other lanes stay unchanged.
REQ-024 An address with any bit at or above ADDR_W nonzero SHALL give resp_err = 1, no write, and rdata 0.
REQ-025 A request arriving while resp_valid and resp_ready are high SHALL NOT be accepted in that cycle; it is accepted in the following IDLE cycle.

Reset
REQ-026 On rst_n = 0: FSM to IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 1 after release.
REQ-027 A reset during WAIT/ACCESS/RESP SHALL abandon the request; a store not yet in ACCESS SHALL NOT be written; memory contents are not cleared.

Configuration
REQ-028 Macro DMEM_MISALIGN_ERR_EN defined: a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL give resp_err = 1 with no write.
REQ-029 Macro DMEM_MISALIGN_ERR_EN undefined: misaligned low address bits SHALL be masked to natural alignment and the access proceeds without error.

Structure
REQ-030 lib_pkg SHALL gain the enum mem_size_t {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU} (3 bits) and the constant DMEM_MAX_WAIT = 15.
REQ-031 The storage SHALL be a sub-module dmem_ram: a synchronous, word-wide, 4-bit byte-enable, single-port RAM with 2^(ADDR_W-2) words.

Verification
REQ-032 SW 0xDEADBEEF @0x010, then LW @0x010 -> rdata 0xDEADBEEF, err 0, latency 3 cycles at WAIT_CYCLES = 1.
REQ-033 After REQ-032: SB 0x80 @0x011; LB @0x011 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x010 -> 0xDEAD80EF.
REQ-034 LH @0x012 -> 0xFFFFDEAD; LHU @0x012 -> 0x0000DEAD.
REQ-035 SW @0x00001000 with ADDR_W = 12 -> err 1; a following LW @0x000 returns its prior value unchanged.
REQ-036 Hold resp_ready = 0 for 5 cycles -> resp_valid and rdata stay stable and req_ready stays 0; a reset asserted mid-WAIT -> resp_valid 0 and the store is not committed.
REQ-037 LW @0x012: with DMEM_MISALIGN_ERR_EN -> err 1; without -> data of word 0x010, err 0.

Source files
------------

// File: rtl/lib_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// byte-lane helper functions used by both the RTL and its bench.
package lib_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd3,
    MEM_HU = 3'd4
  } mem_size_t;

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_WAIT   = 2'd1,
    DM_ACCESS = 2'd2,
    DM_RESP   = 2'd3
  } dmem_state_t;

  localparam int DMEM_MAX_WAIT = 15;

  // Natural alignment of the low address bits for a given access size.
  function automatic logic [1:0] mem_align(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_B, MEM_BU: return off;
      MEM_H, MEM_HU: return {off[1], 1'b0};
      default:       return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] mem_be(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_B, MEM_BU: return 4'b0001 << off;
      MEM_H, MEM_HU: return off[1] ? 4'b1100 : 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane it could land in.
  function automatic logic [31:0] mem_lanes(input mem_size_t size, input logic [31:0] wdata);
    case (size)
      MEM_B, MEM_BU: return {4{wdata[7:0]}};
      MEM_H, MEM_HU: return {2{wdata[15:0]}};
      default:       return wdata;
    endcase
  endfunction

  function automatic logic [31:0] mem_extend(input mem_size_t size, input logic [31:0] word,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_B:   return {{24{sh[7]}}, sh[7:0]};
      MEM_BU:  return {24'd0, sh[7:0]};
      MEM_H:   return {{16{sh[15]}}, sh[15:0]};
      MEM_HU:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port, word-wide data RAM with per-byte write enables and a
// registered (one-cycle) read port. Contents are never reset.
module dmem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, accesses dmem_ram and holds the response until taken.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead
// of masking them to natural alignment.
//
// Handshake: a request transfers on a rising edge with req_valid && req_ready;
// a response transfers on a rising edge with resp_valid && resp_ready, and
// resp_rdata/resp_err are held stable while resp_valid is high.
module dmem_resp
  import lib_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  mem_size_t   req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output dmem_state_t dbg_state
);

  localparam int         WAIT_EFF = (WAIT_CYCLES > DMEM_MAX_WAIT) ? DMEM_MAX_WAIT : WAIT_CYCLES;
  localparam logic [3:0] CNT_LOAD = (WAIT_EFF == 0) ? 4'd0 : 4'(WAIT_EFF - 1);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              acc_phase;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-3:0] lat_waddr;
  logic [1:0]        lat_off;
  mem_size_t         lat_size;
  logic [31:0]       lat_wdata;

  logic              addr_oob;
  logic              misalign;
  logic              req_err;
  logic [1:0]        req_off;

  logic              ram_en;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always_comb begin
    addr_oob = (req_addr >> ADDR_W) != 32'd0;
    req_off  = mem_align(req_size, req_addr[1:0]);
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    // A misaligned access is exactly one whose offset alignment would change.
    misalign = (req_off != req_addr[1:0]);
`endif
    req_err  = addr_oob | misalign;
  end

  // The RAM is touched only in the first ACCESS cycle and never for a faulted
  // request; the second cycle captures the registered read data.
  always_comb begin
    ram_en    = (state == DM_ACCESS) && !acc_phase && !lat_err;
    ram_be    = mem_be(lat_size, lat_off);
    ram_wdata = mem_lanes(lat_size, lat_wdata);
  end

  dmem_ram #(.AW(ADDR_W - 2)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (lat_we),
    .be    (ram_be),
    .addr  (lat_waddr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DM_IDLE;
      cnt        <= 4'd0;
      acc_phase  <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_waddr  <= '0;
      lat_off    <= 2'd0;
      lat_size   <= MEM_W;
      lat_wdata  <= 32'd0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_err   <= req_err;
            lat_waddr <= req_addr[ADDR_W-1:2];
            lat_off   <= req_off;
            lat_size  <= req_size;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            cnt       <= CNT_LOAD;
            state     <= (WAIT_EFF == 0) ? DM_ACCESS : DM_WAIT;
          end
        end
        DM_WAIT: begin
          if (cnt == 4'd0) state <= DM_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        DM_ACCESS: begin
          if (!acc_phase) begin
            acc_phase <= 1'b1;
          end else begin
            acc_phase  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= lat_err;
            resp_rdata <= (lat_we || lat_err) ? 32'd0 : mem_extend(lat_size, ram_rdata, lat_off);
            state      <= DM_RESP;
          end
        end
        DM_RESP: begin
          // req_ready stays low here, so a request seen during the response
          // handshake is only taken in the following IDLE cycle.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            req_ready  <= 1'b1;
            state      <= DM_IDLE;
          end
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized
// loads/stores scored against a byte-array memory model.
module tb_dmem_resp;
  import lib_pkg::*;

  localparam int ADDR_W      = 12;
  localparam int WAIT_CYCLES = 1;
  localparam int MEM_BYTES   = 1 << ADDR_W;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  mem_size_t   req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  dmem_state_t dbg_state;

  dmem_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic [31:0] cur_exp;
  logic        cur_err;
  logic [7:0]  model_mem [0:MEM_BYTES-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input mem_size_t s);
    case (s)
      MEM_B, MEM_BU: return 1;
      MEM_H, MEM_HU: return 2;
      default:       return 4;
    endcase
  endfunction

  function automatic logic model_err(input logic [31:0] addr, input mem_size_t s);
    logic e;
    e = (addr >= 32'(MEM_BYTES));
`ifdef DMEM_MISALIGN_ERR_EN
    if ((addr % 32'(nbytes(s))) != 0) e = 1'b1;
`else
    if (s == MEM_W && 1'b0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input mem_size_t s);
    int          n;
    int          base;
    logic [31:0] v;
    n    = nbytes(s);
    base = int'(addr) - (int'(addr) % n);
    v    = 32'd0;
    for (int i = 0; i < n; i++) v = v + (32'(model_mem[base + i]) << (8 * i));
    // Unsigned wrap-around of the subtraction yields the sign-extended value.
    if (s == MEM_B && v >= 32'd128)   v = v - 32'd256;
    if (s == MEM_H && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input mem_size_t s);
    int n;
    int base;
    n    = nbytes(s);
    base = int'(addr) - (int'(addr) % n);
    for (int i = 0; i < n; i++) model_mem[base + i] = 8'((wdata >> (8 * i)) & 32'hFF);
  endtask

  // ---------------- driver tasks ----------------
  task automatic prep(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input mem_size_t s, input bit commit);
    logic e;
    e = model_err(addr, s);
    err_q.push_back(e);
    exp_q.push_back((we || e) ? 32'd0 : model_load(addr, s));
    if (commit && we && !e) model_store(addr, wdata, s);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = s;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input mem_size_t s, input bit commit);
    int t;
    prep(we, addr, wdata, s, commit);
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) check("req_accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int lat;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    cur_exp = exp_q.pop_front();
    cur_err = err_q.pop_front();
    if (!resp_valid) check({tag, "_resp_timeout"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(2 + WAIT_CYCLES));
    check({tag, "_rdata"}, resp_rdata, cur_exp);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, cur_err});
  endtask

  task automatic recv(input string tag, input int hold);
    resp_ready = (hold == 0);
    wait_resp(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, cur_exp);
      check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_done_req_ready"}, {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input mem_size_t s, input int hold);
    send(we, addr, wdata, s, 1'b1);
    recv(tag, hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_size   = MEM_W;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give the first 16 words known contents.
    for (int w = 0; w < 16; w++) xact("init", 1'b1, 32'(4 * w), $urandom(), MEM_W, 0);

    xact("sw_deadbeef", 1'b1, 32'h010, 32'hDEADBEEF, MEM_W, 0);
    xact("lw_010", 1'b0, 32'h010, 32'd0, MEM_W, 0);
    check("lw_010_literal", cur_exp, 32'hDEADBEEF);
    xact("sb_011", 1'b1, 32'h011, 32'h00000080, MEM_B, 0);
    xact("lb_011", 1'b0, 32'h011, 32'd0, MEM_B, 0);
    check("lb_011_literal", cur_exp, 32'hFFFFFF80);
    xact("lbu_011", 1'b0, 32'h011, 32'd0, MEM_BU, 0);
    xact("lw_010_after_sb", 1'b0, 32'h010, 32'd0, MEM_W, 0);
    check("lw_after_sb_literal", cur_exp, 32'hDEAD80EF);
    xact("lh_012", 1'b0, 32'h012, 32'd0, MEM_H, 0);
    xact("lhu_012", 1'b0, 32'h012, 32'd0, MEM_HU, 0);
    xact("sw_oob", 1'b1, 32'h00001000, 32'h11223344, MEM_W, 0);
    xact("lw_000", 1'b0, 32'h000, 32'd0, MEM_W, 0);
    xact("lw_hold", 1'b0, 32'h010, 32'd0, MEM_W, 5);
    xact("lw_012_misalign", 1'b0, 32'h012, 32'd0, MEM_W, 0);

    // Request presented during the response handshake waits for IDLE.
    send(1'b0, 32'h010, 32'd0, MEM_W, 1'b1);
    resp_ready = 1'b1;
    wait_resp("b2b_first");
    prep(1'b0, 32'h014, 32'd0, MEM_W, 1'b1);
    @(posedge clk); #1;
    check("b2b_handshake_valid", {31'd0, resp_valid}, 32'd0);
    check("b2b_not_taken", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("b2b_taken", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    recv("b2b_second", 0);

    // Reset while the store sits in WAIT: abandoned and never written.
    send(1'b1, 32'h020, 32'hCAFEF00D, MEM_W, 1'b0);
    void'(exp_q.pop_front());
    void'(err_q.pop_front());
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_abandon_valid", {31'd0, resp_valid}, 32'd0);
    end
    xact("lw_020_after_rst", 1'b0, 32'h020, 32'd0, MEM_W, 0);

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      logic        we;
      logic [31:0] addr;
      mem_size_t   s;
      we = 1'($urandom_range(0, 1));
      s  = we ? mem_size_t'(3'($urandom_range(0, 2))) : mem_size_t'(3'($urandom_range(0, 4)));
      case ($urandom_range(0, 9))
        0:       addr = 32'(MEM_BYTES) + 32'($urandom_range(0, 4095));
        1:       addr = $urandom() | 32'h8000_0000;
        default: addr = 32'($urandom_range(0, 63));
      endcase
      xact("rand", we, addr, $urandom(), s, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
